// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin core/aux sequencer for one single-port sync memory; ports: iReq*/iWe*/iAddr*/iWData*/iBe* in, oGnt*/oAck*/oRData* out, oMem* to memory, iMemRData back, oBusy
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iReqC,
  input  logic              iReqA,
  input  logic              iWeC,
  input  logic              iWeA,
  input  logic [ADDR_W-1:0] iAddrC,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [DATA_W-1:0] iWDataC,
  input  logic [DATA_W-1:0] iWDataA,
  input  logic [3:0]        iBeC,
  input  logic [3:0]        iBeA,
  output logic              oGntC,
  output logic              oGntA,
  output logic              oAckC,
  output logic              oAckA,
  output logic [DATA_W-1:0] oRDataC,
  output logic [DATA_W-1:0] oRDataA,
  output logic              oMemEn,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  output logic [3:0]        oMemBe,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oBusy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state, state_n;
  logic last_a, own_a, we, pick_a, start;
  logic [3:0] cnt;
  assign start = state == IDLE && (iReqC || iReqA);
  assign pick_a = iReqA && (!iReqC || !last_a);
  always_ff @(posedge iCLK) state <= iRST ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE  ? (start ? ISSUE : IDLE) :
              state == ISSUE ? (we ? ACK : WAIT) :
              state == WAIT  ? (cnt == 4'd0 ? ACK : WAIT) : IDLE;
    oBusy = state != IDLE;
    oGntC = oBusy && !own_a;
    oGntA = oBusy && own_a;
    oAckC = state == ACK && !own_a;
    oAckA = state == ACK && own_a;
    oMemEn = state == ISSUE;
    oMemWe = state == ISSUE && we;
  end
  always_ff @(posedge iCLK)
    if (iRST) begin
      last_a <= 1'b1;
      own_a <= 1'b0;
      we <= 1'b0;
      cnt <= 4'd0;
      oMemAddr <= '0;
      oMemWData <= '0;
      oMemBe <= 4'h0;
      oRDataC <= '0;
      oRDataA <= '0;
    end else begin
      if (start) begin
        own_a <= pick_a;
        last_a <= pick_a;
        we <= pick_a ? iWeA : iWeC;
        oMemAddr <= pick_a ? iAddrA : iAddrC;
        oMemWData <= pick_a ? iWDataA : iWDataC;
        oMemBe <= pick_a ? (iWeA ? iBeA : 4'h0) : (iWeC ? iBeC : 4'h0);
      end
      if (state == ISSUE || state == WAIT)
        cnt <= state == ISSUE ? 4'(MEM_LAT - 1) : cnt - 4'd1;
      if (state == WAIT && cnt == 4'd0 && own_a)
        oRDataA <= iMemRData;
      if (state == WAIT && cnt == 4'd0 && !own_a)
        oRDataC <= iMemRData;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int ML = 2;
  logic clk = 1'b0, rst = 1'b1, preload = 1'b1, lreq = 1'b0;
  always #5 clk = ~clk;
  logic req_c = 1'b0, req_a = 1'b0, we_c = 1'b0, we_a = 1'b0;
  logic [31:0] addr_c = 32'h0, addr_a = 32'h0, wdata_c = 32'h0, wdata_a = 32'h0;
  logic [3:0] be_c = 4'h0, be_a = 4'h0;
  logic gnt_c, gnt_a, ack_c, ack_a, mem_en, mem_we, busy;
  logic [31:0] rdata_c, rdata_a, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  int total = 0, bad = 0;
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(ML)) dut (
    .iCLK(clk), .iRST(rst), .iReqC(req_c), .iReqA(req_a), .iWeC(we_c), .iWeA(we_a),
    .iAddrC(addr_c), .iAddrA(addr_a), .iWDataC(wdata_c), .iWDataA(wdata_a),
    .iBeC(be_c), .iBeA(be_a), .oGntC(gnt_c), .oGntA(gnt_a), .oAckC(ack_c), .oAckA(ack_a),
    .oRDataC(rdata_c), .oRDataA(rdata_a), .oMemEn(mem_en), .oMemWe(mem_we),
    .oMemAddr(mem_addr), .oMemWData(mem_wdata), .oMemBe(mem_be), .iMemRData(mem_rdata),
    .oBusy(busy));
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [15:0] pend;
  logic [7:0] rd_addr;
  logic [31:0] noise;
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction
  always @(posedge clk) begin
    noise <= $urandom;
    pend <= preload ? 16'h0 : {pend[14:0], mem_en & ~mem_we};
    if (mem_en) rd_addr <= mem_addr[7:0];
    for (int i = 0; i < 256; i++) if (preload) mem[i] <= (i == 16) ? 32'hDEADBEEF : 32'h0;
    if (!preload && mem_en && mem_we) mem[mem_addr[7:0]] <= merge(mem[mem_addr[7:0]], mem_wdata, mem_be);
  end
  assign mem_rdata = pend[ML-1] ? mem[rd_addr] : noise;
  logic l_ack [2];
  logic [31:0] l_rd [2];
  for (genvar g = 0; g < 2; g++) begin : lat
    localparam int L = g ? 15 : 1;
    logic gc, ga, aa, en, we, bz;
    logic [31:0] ra, ma, mw, rd;
    logic [3:0] mb;
    logic [15:0] pd;
    always @(posedge clk) pd <= preload ? 16'h0 : {pd[14:0], en & ~we};
    assign rd = pd[L-1] ? (32'hA5A50000 | L) : noise;
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u (
      .iCLK(clk), .iRST(rst), .iReqC(lreq), .iReqA(1'b0), .iWeC(1'b0), .iWeA(1'b0),
      .iAddrC(32'h40), .iAddrA(32'h0), .iWDataC(32'h0), .iWDataA(32'h0),
      .iBeC(4'h0), .iBeA(4'h0), .oGntC(gc), .oGntA(ga), .oAckC(l_ack[g]), .oAckA(aa),
      .oRDataC(l_rd[g]), .oRDataA(ra), .oMemEn(en), .oMemWe(we), .oMemAddr(ma),
      .oMemWData(mw), .oMemBe(mb), .iMemRData(rd), .oBusy(bz));
  end
  bit m_last_a;
  logic [31:0] m_rd_c, m_rd_a;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin bad++; $error("FAIL %s: got %h want %h", tag, obs, exp); end
  endtask
  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin bad++; $error("FAIL %s: got %b want %b", tag, obs, exp); end
  endtask
  task automatic run_one(input bit a, input bit we, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] be);
    int t;
    bit got;
    if (a) begin req_a = 1'b1; we_a = we; addr_a = ad; wdata_a = wd; be_a = be; end
    else begin req_c = 1'b1; we_c = we; addr_c = ad; wdata_c = wd; be_c = be; end
    @(negedge clk);
    req_a = 1'b0;
    req_c = 1'b0;
    chk1("issue_en", mem_en, 1'b1);
    chk1("issue_we", mem_we, we);
    chk1("issue_gnt", a ? gnt_a : gnt_c, 1'b1);
    chk("issue_addr", mem_addr, ad);
    chk("issue_be", {28'h0, mem_be}, {28'h0, we ? be : 4'h0});
    if (we) chk("issue_wdata", mem_wdata, wd);
    t = 1;
    got = 1'b0;
    while (!got && t < 40) begin
      @(negedge clk);
      t++;
      got = a ? ack_a : ack_c;
    end
    chk("ack_latency", t, we ? 2 : ML + 2);
    m_last_a = a;
    if (we) ref_mem[ad[7:0]] = merge(ref_mem[ad[7:0]], wd, be);
    else if (a) m_rd_a = ref_mem[ad[7:0]];
    else m_rd_c = ref_mem[ad[7:0]];
    chk("rdata_c", rdata_c, m_rd_c);
    chk("rdata_a", rdata_a, m_rd_a);
    @(negedge clk);
    chk1("ack_pulse", a ? ack_a : ack_c, 1'b0);
    chk1("back_idle", busy, 1'b0);
  endtask
  int l_t [2];
  int nc, na, prev_en, t, done [2], p_start [2];
  bit nxt_a, prev_c, prev_a, q, ak;
  bit p_on [2], p_we [2];
  logic [31:0] p_ad [2], p_wd [2];
  logic [3:0] p_be [2];
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = (i == 16) ? 32'hDEADBEEF : 32'h0;
    m_last_a = 1'b1;
    m_rd_c = 32'h0;
    m_rd_a = 32'h0;
    repeat (3) @(negedge clk);
    chk1("rst_gnt_c", gnt_c, 1'b0);
    chk1("rst_gnt_a", gnt_a, 1'b0);
    chk1("rst_ack_c", ack_c, 1'b0);
    chk1("rst_ack_a", ack_a, 1'b0);
    chk1("rst_en", mem_en, 1'b0);
    chk1("rst_we", mem_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_rdata_c", rdata_c, 32'h0);
    chk("rst_rdata_a", rdata_a, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    rst = 1'b0;
    preload = 1'b0;
    run_one(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("rd_0x10", rdata_c, 32'hDEADBEEF);
    repeat (3) begin @(negedge clk); chk1("no_second", busy, 1'b0); end
    lreq = 1'b1;
    l_t[0] = 0;
    l_t[1] = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      lreq = 1'b0;
      for (int g = 0; g < 2; g++) if (l_ack[g] && l_t[g] == 0) begin
        l_t[g] = k;
        chk("lat_rdata", l_rd[g], 32'hA5A50000 | (g ? 15 : 1));
      end
    end
    chk("lat1_ack", l_t[0], 3);
    chk("lat15_ack", l_t[1], 17);
    run_one(1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011);
    run_one(1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("readback_0x20", rdata_c, 32'h00005678);
    req_c = 1'b1;
    we_c = 1'b0;
    addr_c = 32'h10;
    @(negedge clk);
    req_c = 1'b0;
    @(negedge clk);
    chk1("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last_a = 1'b1;
    m_rd_c = 32'h0;
    m_rd_a = 32'h0;
    chk1("wrst_busy", busy, 1'b0);
    chk1("wrst_gnt_c", gnt_c, 1'b0);
    chk1("wrst_en", mem_en, 1'b0);
    chk("wrst_rdata_c", rdata_c, 32'h0);
    chk("wrst_addr", mem_addr, 32'h0);
    chk("wrst_be", {28'h0, mem_be}, 32'h0);
    repeat (6) begin @(negedge clk); chk1("wrst_no_ack", ack_c, 1'b0); end
    nc = 0;
    na = 0;
    prev_en = -1;
    prev_c = 1'b0;
    prev_a = 1'b0;
    nxt_a = !m_last_a;
    req_c = 1'b1;
    req_a = 1'b1;
    we_c = 1'b0;
    we_a = 1'b0;
    addr_c = $urandom_range(0, 255);
    addr_a = $urandom_range(0, 255);
    for (int k = 0; k < 60 && (nc < 2 || na < 2); k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (prev_en >= 0) chk("tie_en_gap", k - prev_en, ML + 3);
        prev_en = k;
        chk1("tie_gnt", gnt_a, nxt_a);
      end
      if (ack_c || ack_a) begin
        chk1("tie_order", ack_a, nxt_a);
        chk1("tie_ack_pulse", ack_a ? prev_a : prev_c, 1'b0);
        if (ack_a) begin
          m_rd_a = ref_mem[addr_a[7:0]];
          na++;
          if (na == 2) req_a = 1'b0; else addr_a = $urandom_range(0, 255);
        end else begin
          m_rd_c = ref_mem[addr_c[7:0]];
          nc++;
          if (nc == 2) req_c = 1'b0; else addr_c = $urandom_range(0, 255);
        end
        m_last_a = ack_a;
        nxt_a = !nxt_a;
        chk("tie_rdata_c", rdata_c, m_rd_c);
        chk("tie_rdata_a", rdata_a, m_rd_a);
      end
      prev_c = ack_c;
      prev_a = ack_a;
    end
    chk("tie_count_c", nc, 2);
    chk("tie_count_a", na, 2);
    for (int p = 0; p < 2; p++) begin p_on[p] = 1'b0; done[p] = 0; end
    prev_c = 1'b0;
    prev_a = 1'b0;
    t = 0;
    while (t < 3000 && (done[0] < 30 || done[1] < 30)) begin
      @(negedge clk);
      t++;
      for (int p = 0; p < 2; p++) begin
        ak = p ? ack_a : ack_c;
        if (ak) begin
          chk1("rnd_ack_owner", p_on[p], 1'b1);
          chk1("rnd_ack_pulse", p ? prev_a : prev_c, 1'b0);
          chk1("rnd_wait_bound", (t - p_start[p]) <= 2 * ML + 6, 1'b1);
          if (p_we[p]) ref_mem[p_ad[p][7:0]] = merge(ref_mem[p_ad[p][7:0]], p_wd[p], p_be[p]);
          else if (p == 1) m_rd_a = ref_mem[p_ad[p][7:0]];
          else m_rd_c = ref_mem[p_ad[p][7:0]];
          p_on[p] = 1'b0;
          done[p]++;
          m_last_a = (p == 1);
        end
      end
      chk("rnd_rdata_c", rdata_c, m_rd_c);
      chk("rnd_rdata_a", rdata_a, m_rd_a);
      if (mem_en) begin
        chk1("rnd_one_gnt", gnt_c ^ gnt_a, 1'b1);
        q = gnt_a;
        chk1("rnd_issue_pending", p_on[q], 1'b1);
        chk("rnd_issue_addr", mem_addr, p_ad[q]);
        chk1("rnd_issue_we", mem_we, p_we[q]);
        chk("rnd_issue_be", {28'h0, mem_be}, {28'h0, p_we[q] ? p_be[q] : 4'h0});
        if (p_we[q]) chk("rnd_issue_wdata", mem_wdata, p_wd[q]);
      end
      prev_c = ack_c;
      prev_a = ack_a;
      for (int p = 0; p < 2; p++) if (!p_on[p] && $urandom_range(0, 2) == 0) begin
        p_on[p] = 1'b1;
        p_we[p] = 1'($urandom_range(0, 1));
        p_ad[p] = $urandom_range(0, 255);
        p_wd[p] = $urandom;
        p_be[p] = 4'($urandom_range(0, 15));
        p_start[p] = t;
      end
      req_c = p_on[0]; we_c = p_we[0]; addr_c = p_ad[0]; wdata_c = p_wd[0]; be_c = p_be[0];
      req_a = p_on[1]; we_a = p_we[1]; addr_a = p_ad[1]; wdata_a = p_wd[1]; be_a = p_be[1];
    end
    chk1("rnd_progress_c", done[0] >= 30, 1'b1);
    chk1("rnd_progress_a", done[1] >= 30, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
